// File: rtl/msh_rd_rsp.sv
// Mesh-node read responder: accepts in-order read requests, issues bank reads and
// queues {tag, data} responses in a credit-protected FIFO drained under valid/ready.
`timescale 1ns/1ps

module msh_rd_rsp #(
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 6,
    parameter int MEM_RD_LAT = 2,
    parameter int RSP_DEPTH  = 8,
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1)
) (
    input  logic              mclk,
    input  logic              mrst,
    input  logic              rd_req_vld,
    output logic              rd_req_rdy,
    input  logic [BANK_W-1:0] rd_req_bank,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic [TAG_W-1:0]  rd_req_tag,
    output logic              mem_rd_en,
    output logic [BANK_W-1:0] mem_rd_bank,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [DATA_W-1:0] rsp_data,
    output logic [CNT_W-1:0]  inflight_cnt
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RSP_DEPTH);

    logic                              mrst_q, mrst_d;
    logic [MEM_RD_LAT:0]               pipe_vld_q, pipe_vld_d;
    logic [MEM_RD_LAT:0][TAG_W-1:0]    pipe_tag_q, pipe_tag_d;
    logic [BANK_W-1:0]                 rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0]                 rd_addr_q, rd_addr_d;
    logic [PTR_W:0]                    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]                    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;

    logic [TAG_W-1:0]  fifo_tag_q  [RSP_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [RSP_DEPTH];

    logic accept;
    logic pop;
    logic fifo_wr;
    logic fifo_empty;
    logic fifo_full;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;

    always_comb begin
        // NOTE: every signal gets a value on every path through this block, so no latches are inferred.
        mrst_d     = mrst;
        wr_idx     = wr_ptr_q[PTR_W-1:0];
        rd_idx     = rd_ptr_q[PTR_W-1:0];
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);

        // Ready comes from registered state only; a credit is reserved at accept time.
        rd_req_rdy = !mrst_q && (cnt_q < DEPTH_CNT);
        accept     = rd_req_vld && rd_req_rdy;
        rsp_vld    = !fifo_empty;
        pop        = rsp_vld && rsp_rdy;
        fifo_wr    = pipe_vld_q[MEM_RD_LAT];

        pipe_vld_d = {pipe_vld_q[MEM_RD_LAT-1:0], accept};
        pipe_tag_d = {pipe_tag_q[MEM_RD_LAT-1:0], rd_req_tag};
        rd_bank_d  = accept ? rd_req_bank : rd_bank_q;
        rd_addr_d  = accept ? rd_req_addr : rd_addr_q;

        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, fifo_wr};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};

        cnt_d = cnt_q;
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        mem_rd_en    = pipe_vld_q[0];
        mem_rd_bank  = rd_bank_q;
        mem_rd_addr  = rd_addr_q;
        inflight_cnt = cnt_q;
        rsp_tag      = rsp_vld ? fifo_tag_q[rd_idx]  : '0;
        rsp_data     = rsp_vld ? fifo_data_q[rd_idx] : '0;
    end

    always_ff @(posedge mclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        mrst_q <= mrst_d;
        if (mrst) begin
            pipe_vld_q <= '0;
            pipe_tag_q <= '0;
            rd_bank_q  <= '0;
            rd_addr_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            pipe_tag_q <= pipe_tag_d;
            rd_bank_q  <= rd_bank_d;
            rd_addr_q  <= rd_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // NOTE: the storage array is not reset; the pointers alone decide what is visible.
    always_ff @(posedge mclk) begin
        if (!mrst && fifo_wr) begin
            fifo_tag_q[wr_idx]  <= pipe_tag_q[MEM_RD_LAT];
            fifo_data_q[wr_idx] <= mem_rd_data;
        end
    end

    a_cnt_bound: assert property (@(posedge mclk) disable iff (mrst) cnt_q <= DEPTH_CNT);
    a_no_ovf:    assert property (@(posedge mclk) disable iff (mrst) !(fifo_wr && fifo_full));
    a_no_udf:    assert property (@(posedge mclk) disable iff (mrst) !(pop && fifo_empty));
    a_bank_ok:   assert property (@(posedge mclk) disable iff (mrst)
                                  accept |-> (32'(rd_req_bank) < NUM_BANKS));

endmodule

// File: tb/tb_msh_rd_rsp.sv
// Self-checking bench for msh_rd_rsp: a directed vector table, multi-cycle corner
// sequences and a long random run, all compared against a request-queue reference model.
`timescale 1ns/1ps

module tb_msh_rd_rsp;

    localparam int NUM_BANKS  = 4;
    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 64;
    localparam int TAG_W      = 6;
    localparam int MEM_RD_LAT = 2;
    localparam int RSP_DEPTH  = 8;
    localparam int BANK_W     = 2;
    localparam int CNT_W      = 4;

    logic              mclk = 1'b0;
    logic              mrst;
    logic              rd_req_vld;
    logic              rd_req_rdy;
    logic [BANK_W-1:0] rd_req_bank;
    logic [ADDR_W-1:0] rd_req_addr;
    logic [TAG_W-1:0]  rd_req_tag;
    logic              mem_rd_en;
    logic [BANK_W-1:0] mem_rd_bank;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              rsp_vld;
    logic              rsp_rdy;
    logic [TAG_W-1:0]  rsp_tag;
    logic [DATA_W-1:0] rsp_data;
    logic [CNT_W-1:0]  inflight_cnt;

    always #5 mclk = ~mclk;

    msh_rd_rsp #(
        .NUM_BANKS (NUM_BANKS),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .TAG_W     (TAG_W),
        .MEM_RD_LAT(MEM_RD_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .mclk        (mclk),
        .mrst        (mrst),
        .rd_req_vld  (rd_req_vld),
        .rd_req_rdy  (rd_req_rdy),
        .rd_req_bank (rd_req_bank),
        .rd_req_addr (rd_req_addr),
        .rd_req_tag  (rd_req_tag),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_bank (mem_rd_bank),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .rsp_vld     (rsp_vld),
        .rsp_rdy     (rsp_rdy),
        .rsp_tag     (rsp_tag),
        .rsp_data    (rsp_data),
        .inflight_cnt(inflight_cnt)
    );

    // Outstanding request as seen by the requester: visible once its fixed latency elapses.
    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [BANK_W-1:0] bank;
        logic [ADDR_W-1:0] addr;
        int                ready_cyc;
    } req_t;

    typedef struct {
        bit                rst, vld, rrdy;
        logic [BANK_W-1:0] bank;
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
        bit                e_rdy, e_en, e_vld, chk_td;
        logic [BANK_W-1:0] e_bank;
        logic [ADDR_W-1:0] e_addr;
        logic [TAG_W-1:0]  e_tag;
        logic [DATA_W-1:0] e_data;
        logic [CNT_W-1:0]  e_cnt;
    } vec_t;

    req_t              model_q[$];
    vec_t              vecs[$];
    vec_t              cur_row;
    bit                row_en;
    bit                chk_en;
    bit                model_prev_mrst;
    bit                last_acc;
    logic [BANK_W-1:0] last_bank;
    logic [ADDR_W-1:0] last_addr;
    bit                hist_vld [MEM_RD_LAT];
    logic [DATA_W-1:0] hist_dat [MEM_RD_LAT];
    logic [TAG_W-1:0]  dut_pop_tag;
    int                cyc;
    int                pops;
    int                n_checks;
    int                n_errors;

    function automatic logic [DATA_W-1:0] mem_val(input logic [BANK_W-1:0] b, input logic [ADDR_W-1:0] a);
        logic [31:0] h;
        h = (32'(a) * 32'h9E3779B1) ^ (32'(b) * 32'h01000193) ^ 32'h5A5A0000;
        return {16'(b), 16'(a), h};
    endfunction

    function automatic vec_t mk(input bit rst, input bit vld, input bit rrdy, input int bank,
                                input int addr, input int tag, input bit e_rdy, input bit e_en,
                                input int e_bank, input int e_addr, input bit e_vld, input bit chk_td,
                                input int e_tag, input logic [DATA_W-1:0] e_data, input int e_cnt);
        vec_t v;
        v.rst = rst;  v.vld = vld;  v.rrdy = rrdy;
        v.bank = BANK_W'(bank);  v.addr = ADDR_W'(addr);  v.tag = TAG_W'(tag);
        v.e_rdy = e_rdy;  v.e_en = e_en;  v.e_vld = e_vld;  v.chk_td = chk_td;
        v.e_bank = BANK_W'(e_bank);  v.e_addr = ADDR_W'(e_addr);  v.e_tag = TAG_W'(e_tag);
        v.e_data = e_data;  v.e_cnt = CNT_W'(e_cnt);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: memory model, checks at the falling edge, model advance, then the rising edge.
    task automatic step();
        bit exp_rdy, exp_vld, pop;
        @(negedge mclk);
        mem_rd_data = hist_vld[MEM_RD_LAT-1] ? hist_dat[MEM_RD_LAT-1] : {$urandom, $urandom};
        for (int i = MEM_RD_LAT - 1; i > 0; i--) begin
            hist_vld[i] = hist_vld[i-1];
            hist_dat[i] = hist_dat[i-1];
        end
        hist_vld[0] = mem_rd_en;
        hist_dat[0] = mem_val(mem_rd_bank, mem_rd_addr);

        exp_rdy = !model_prev_mrst && (model_q.size() < RSP_DEPTH);
        exp_vld = (model_q.size() > 0) && (model_q[0].ready_cyc <= cyc);

        if (chk_en) begin
            check("req_rdy", 64'(rd_req_rdy), 64'(exp_rdy));
            check("inflight_cnt", 64'(inflight_cnt), 64'(model_q.size()));
            check("rsp_vld", 64'(rsp_vld), 64'(exp_vld));
            check("mem_rd_en", 64'(mem_rd_en), 64'(last_acc));
            if (last_acc) begin
                check("mem_rd_bank", 64'(mem_rd_bank), 64'(last_bank));
                check("mem_rd_addr", 64'(mem_rd_addr), 64'(last_addr));
            end
            if (exp_vld) begin
                check("rsp_tag", 64'(rsp_tag), 64'(model_q[0].tag));
                check("rsp_data", rsp_data, mem_val(model_q[0].bank, model_q[0].addr));
            end
        end

        if (row_en) begin
            check("vec_rdy", 64'(rd_req_rdy), 64'(cur_row.e_rdy));
            check("vec_en", 64'(mem_rd_en), 64'(cur_row.e_en));
            check("vec_vld", 64'(rsp_vld), 64'(cur_row.e_vld));
            check("vec_cnt", 64'(inflight_cnt), 64'(cur_row.e_cnt));
            if (cur_row.e_en) begin
                check("vec_bank", 64'(mem_rd_bank), 64'(cur_row.e_bank));
                check("vec_addr", 64'(mem_rd_addr), 64'(cur_row.e_addr));
            end
            if (cur_row.e_vld || cur_row.chk_td) begin
                check("vec_tag", 64'(rsp_tag), 64'(cur_row.e_tag));
                check("vec_data", rsp_data, cur_row.e_data);
            end
        end

        if (mrst) begin
            model_q.delete();
            last_acc        = 1'b0;
            model_prev_mrst = 1'b1;
        end else begin
            pop = exp_vld && rsp_rdy;
            if (pop) begin
                pops++;
                dut_pop_tag = rsp_tag;
                void'(model_q.pop_front());
            end
            last_acc = rd_req_vld && exp_rdy;
            if (last_acc) begin
                model_q.push_back('{tag: rd_req_tag, bank: rd_req_bank, addr: rd_req_addr,
                                    ready_cyc: cyc + MEM_RD_LAT + 2});
                last_bank = rd_req_bank;
                last_addr = rd_req_addr;
            end
            model_prev_mrst = 1'b0;
        end
        @(posedge mclk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string name);
        int g;
        rd_req_vld = 1'b0;
        rsp_rdy    = 1'b1;
        g = 0;
        while (inflight_cnt != '0 && g < 100) begin
            step();
            g++;
        end
        check(name, 64'(inflight_cnt), 64'd0);
    endtask

    task automatic rand_req();
        rd_req_bank = BANK_W'($urandom_range(0, NUM_BANKS - 1));
        rd_req_addr = ADDR_W'($urandom);
    endtask

    initial begin
        int issued, stalls, g, p0;
        mrst = 1'b1;  rd_req_vld = 1'b0;  rsp_rdy = 1'b0;
        rd_req_bank = '0;  rd_req_addr = '0;  rd_req_tag = '0;  mem_rd_data = '0;
        for (int i = 0; i < MEM_RD_LAT; i++) begin
            hist_vld[i] = 1'b0;
            hist_dat[i] = '0;
        end
        cyc = 0;  pops = 0;  n_checks = 0;  n_errors = 0;
        chk_en = 1'b0;  row_en = 1'b0;  model_prev_mrst = 1'b1;  last_acc = 1'b0;
        last_bank = '0;  last_addr = '0;  dut_pop_tag = '0;
        step();
        step();
        chk_en = 1'b1;

        // rst vld rrdy bank addr tag | rdy en e_bank e_addr vld chk_td e_tag e_data cnt
        vecs.push_back(mk(1, 0, 0, 0, 'h000, 'h00, 0, 0, 0, 'h000, 0, 1, 'h00, '0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 'h000, 'h00, 0, 0, 0, 'h000, 0, 1, 'h00, '0, 0));
        vecs.push_back(mk(0, 1, 0, 2, 'h05A, 'h11, 1, 0, 0, 'h000, 0, 0, 'h00, '0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 'h000, 'h00, 1, 1, 2, 'h05A, 0, 0, 'h00, '0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 'h000, 'h00, 1, 0, 0, 'h000, 0, 0, 'h00, '0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 'h000, 'h00, 1, 0, 0, 'h000, 0, 0, 'h00, '0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 'h000, 'h00, 1, 0, 0, 'h000, 1, 0, 'h11, mem_val(2, 'h05A), 1));
        vecs.push_back(mk(0, 0, 1, 0, 'h000, 'h00, 1, 0, 0, 'h000, 1, 0, 'h11, mem_val(2, 'h05A), 1));
        vecs.push_back(mk(0, 0, 1, 0, 'h000, 'h00, 1, 0, 0, 'h000, 0, 0, 'h00, '0, 0));
        vecs.push_back(mk(0, 1, 1, 3, 'hFFF, 'h3F, 1, 0, 0, 'h000, 0, 0, 'h00, '0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 'h000, 'h00, 1, 1, 3, 'hFFF, 0, 0, 'h00, '0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 'h000, 'h00, 1, 1, 0, 'h000, 0, 0, 'h00, '0, 2));
        vecs.push_back(mk(0, 0, 1, 0, 'h000, 'h00, 1, 0, 0, 'h000, 0, 0, 'h00, '0, 2));
        vecs.push_back(mk(0, 0, 1, 0, 'h000, 'h00, 1, 0, 0, 'h000, 1, 0, 'h3F, mem_val(3, 'hFFF), 2));
        vecs.push_back(mk(0, 0, 1, 0, 'h000, 'h00, 1, 0, 0, 'h000, 1, 0, 'h00, mem_val(0, 'h000), 1));
        vecs.push_back(mk(0, 0, 1, 0, 'h000, 'h00, 1, 0, 0, 'h000, 0, 0, 'h00, '0, 0));

        row_en = 1'b1;
        foreach (vecs[i]) begin
            cur_row     = vecs[i];
            mrst        = cur_row.rst;
            rd_req_vld  = cur_row.vld;
            rsp_rdy     = cur_row.rrdy;
            rd_req_bank = cur_row.bank;
            rd_req_addr = cur_row.addr;
            rd_req_tag  = cur_row.tag;
            step();
        end
        row_en = 1'b0;

        // Streaming at full rate: the requester must never stall.
        p0 = pops;  issued = 0;  stalls = 0;  g = 0;
        rsp_rdy = 1'b1;  rd_req_vld = 1'b1;
        while (issued < 32 && g < 200) begin
            rd_req_tag = TAG_W'(issued);
            rand_req();
            step();
            if (last_acc) issued++;
            else stalls++;
            g++;
        end
        check("stream_stalls", 64'(stalls), 64'd0);
        drain("stream_drain");
        check("stream_pops", 64'(pops - p0), 64'd32);

        // Backpressure: only RSP_DEPTH requests can hold credits.
        p0 = pops;  issued = 0;
        rsp_rdy = 1'b0;  rd_req_vld = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rd_req_tag = TAG_W'(6'h20 + issued);
            rand_req();
            step();
            if (last_acc) issued++;
        end
        check("bp_accepted", 64'(issued), 64'd8);
        check("bp_rdy_low", 64'(rd_req_rdy), 64'd0);
        check("bp_cnt_full", 64'(inflight_cnt), 64'd8);
        rsp_rdy = 1'b1;  g = 0;
        while (issued < 10 && g < 100) begin
            rd_req_tag = TAG_W'(6'h20 + issued);
            rand_req();
            step();
            if (last_acc) issued++;
            g++;
        end
        drain("bp_drain");
        check("bp_pops", 64'(pops - p0), 64'd10);

        // Seven credits held, then accept+pop every cycle over several pointer laps.
        issued = 0;  g = 0;
        rsp_rdy = 1'b0;  rd_req_vld = 1'b1;
        while (issued < 7 && g < 50) begin
            rd_req_tag = TAG_W'(issued);
            rand_req();
            step();
            if (last_acc) issued++;
            g++;
        end
        rsp_rdy = 1'b1;  stalls = 0;
        for (int i = 0; i < 30; i++) begin
            rd_req_tag = TAG_W'(issued);
            rand_req();
            step();
            if (last_acc) issued++;
            else stalls++;
            check("lap_cnt", 64'(inflight_cnt), 64'd7);
        end
        check("lap_stalls", 64'(stalls), 64'd0);
        drain("lap_drain");

        // Reset with reads in the pipe and responses queued.
        issued = 0;  g = 0;
        rsp_rdy = 1'b0;  rd_req_vld = 1'b1;
        while (issued < 6 && g < 50) begin
            rd_req_tag = TAG_W'(6'h30 + issued);
            rand_req();
            step();
            if (last_acc) issued++;
            g++;
        end
        rd_req_vld = 1'b0;  mrst = 1'b1;
        step();
        mrst = 1'b0;
        check("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        check("rst_cnt", 64'(inflight_cnt), 64'd0);
        check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        for (int i = 0; i < 6; i++) step();
        p0 = pops;  g = 0;
        rsp_rdy = 1'b1;  rd_req_vld = 1'b1;  rd_req_tag = 6'h3F;
        rand_req();
        while (!last_acc && g < 20) begin
            step();
            g++;
        end
        rd_req_vld = 1'b0;
        drain("rst_drain");
        check("rst_new_pops", 64'(pops - p0), 64'd1);
        check("rst_new_tag", 64'(dut_pop_tag), 64'h3F);

        // Long random run against the reference model.
        for (int i = 0; i < 10000; i++) begin
            mrst       = ($urandom_range(0, 499) == 0);
            rd_req_vld = ($urandom_range(0, 99) < 70);
            rsp_rdy    = ($urandom_range(0, 99) < 60);
            rd_req_tag = TAG_W'($urandom);
            rand_req();
            step();
        end
        mrst = 1'b0;
        drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
